// File: rtl/jtkcpu_sdiv_pkg.sv
// Shared helpers for the jtkcpu iterative divider: operand widths and
// conditional two's-complement negation used for magnitude extraction
// and for applying result signs.
package jtkcpu_sdiv_pkg;

   localparam int QW = 16;
   localparam int RW = 8;

   // Negate a 16-bit value when en is set, pass it through otherwise
   function automatic logic [QW-1:0] neg16(input logic [QW-1:0] x, input logic en);
      return en ? (~x + 16'd1) : x;
   endfunction

   // Negate an 8-bit value when en is set, pass it through otherwise
   function automatic logic [RW-1:0] neg8(input logic [RW-1:0] x, input logic en);
      return en ? (~x + 8'd1) : x;
   endfunction

endpackage

// File: rtl/jtkcpu_sdiv.sv
// Iterative signed/unsigned 16/8 and 8/8 divider for the jtkcpu ALU.
// Restoring division on operand magnitudes, one quotient bit per enabled
// clock, with signs reapplied when the result is loaded.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   IDLE    | waiting for start; outputs hold the last result
//   RUN     | iterating quotient bits 1..N-1
//   DONE    | last quotient bit (or divide-by-zero), outputs loaded, busy falls
module jtkcpu_sdiv
   import jtkcpu_sdiv_pkg::*;
(
   input  logic          rst,
   input  logic          clk,
   input  logic          cen,
   input  logic [15:0]   op0,
   input  logic [7:0]    op1,
   input  logic          len,
   input  logic          sign,
   input  logic          start,
   output logic [15:0]   quot,
   output logic [7:0]    rem,
   output logic          busy,
   output logic          v
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   // Counter preloads: RUN covers N-1 bits, DONE produces the final one
   localparam logic [3:0] CNT16 = 4'd14;
   localparam logic [3:0] CNT8  = 4'd6;

   logic [1:0]  st;
   logic [3:0]  cnt;
   logic [15:0] dvd;      // dividend magnitude shifting out, quotient shifting in
   logic [8:0]  pr;       // partial remainder
   logic [7:0]  dvs;      // divisor magnitude
   logic        l_len;
   logic        l_sign;
   logic        qneg;
   logic        rneg;
   logic        dz;

   logic        a_neg;
   logic        b_neg;
   logic [8:0]  pr_sh;
   logic        ge;
   logic [8:0]  pr_nx;
   logic [15:0] dvd_nx;
   logic        ovf;
   logic [15:0] q_res;
   logic [7:0]  r_res;

   // Operand signs at acceptance time
   always_comb begin
      a_neg = sign & (len ? op0[15] : op0[7]);
      b_neg = sign & op1[7];
   end

   // One restoring-division step plus the signed result formatting
   always_comb begin
      pr_sh  = {pr[7:0], dvd[15]};
      ge     = pr_sh >= {1'b0, dvs};
      pr_nx  = ge ? (pr_sh - {1'b0, dvs}) : pr_sh;
      dvd_nx = {dvd[14:0], ge};
      // Only a positive quotient can exceed the signed range; its magnitude
      // is at most 2^(width-1), so the top bit of the width flags it.
      ovf    = l_sign & ~qneg & (l_len ? dvd_nx[15] : dvd_nx[7]);
      q_res  = neg16(dvd_nx, qneg);
      r_res  = ovf ? 8'h00 : neg8(pr_nx[7:0], rneg);
   end

   // Divider state machine and datapath
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         st     <= ST_IDLE;
         cnt    <= 4'd0;
         dvd    <= 16'd0;
         pr     <= 9'd0;
         dvs    <= 8'd0;
         l_len  <= 1'b0;
         l_sign <= 1'b0;
         qneg   <= 1'b0;
         rneg   <= 1'b0;
         dz     <= 1'b0;
         quot   <= 16'd0;
         rem    <= 8'd0;
         busy   <= 1'b0;
         v      <= 1'b0;
      end else if (cen) begin
         case (st)
            ST_IDLE: begin
               if (start) begin
                  busy   <= 1'b1;
                  l_len  <= len;
                  l_sign <= sign;
                  qneg   <= a_neg ^ b_neg;
                  rneg   <= a_neg;
                  dvs    <= neg8(op1, b_neg);
                  pr     <= 9'd0;
                  cnt    <= len ? CNT16 : CNT8;
                  if (op1 == 8'd0) begin
                     dz  <= 1'b1;
                     dvd <= op0;
                     st  <= ST_DONE;
                  end else begin
                     dz  <= 1'b0;
                     dvd <= len ? neg16(op0, a_neg) : {neg8(op0[7:0], a_neg), 8'h00};
                     st  <= ST_RUN;
                  end
               end
            end
            ST_RUN: begin
               dvd <= dvd_nx;
               pr  <= pr_nx;
               if (cnt == 4'd0) st <= ST_DONE;
               else cnt <= cnt - 4'd1;
            end
            ST_DONE: begin
               busy <= 1'b0;
               st   <= ST_IDLE;
               if (dz) begin
                  quot <= 16'hFFFF;
                  rem  <= dvd[7:0];
                  v    <= 1'b1;
               end else begin
                  quot <= q_res;
                  rem  <= r_res;
                  v    <= ovf;
               end
            end
            default: begin
               st   <= ST_IDLE;
               busy <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: doc/jtkcpu_sdiv.md
# jtkcpu_sdiv

Iterative signed/unsigned divider, the responder side of the ALU's divide handshake. The ALU pulses `start` with a 16-bit or 8-bit dividend and an 8-bit divisor, then stalls on `busy`. This block produces a 16-bit quotient, an 8-bit remainder and an overflow flag. It computes one quotient bit per enabled clock and is gated by the CPU clock enable. It sits inside the ALU and serves DIVXB and any future signed-divide opcode.

## Interface
- No parameters.
- `rst` input 1: reset, asynchronous, active-high.
- `clk` input 1: CPU clock.
- `cen` input 1: clock enable; all state advances only when high.
- `op0` input 16: dividend. When `len=0`, only `op0[7:0]` is used.
- `op1` input 8: divisor.
- `len` input 1: 1 selects 16/8 division, 0 selects 8/8 division.
- `sign` input 1: 1 treats operands as two's complement, 0 treats them as unsigned.
- `start` input 1: request, sampled on `cen` cycles.
- `quot` output 16: quotient, registered.
- `rem` output 8: remainder, registered.
- `busy` output 1: high while a division is in progress.
- `v` output 1: overflow or divide-by-zero, registered.

## Operation
- Reset values: `quot=0`, `rem=0`, `busy=0`, `v=0`. The internal state machine resets to IDLE.
- States:
  - IDLE: waits for a request.
  - RUN: iterates one bit per `cen` cycle.
  - DONE: loads the outputs.
- Request acceptance: `start=1` with `cen=1` in IDLE is accepted. In any other state `start` is ignored; the in-flight division continues unchanged.
- On acceptance, the block latches `len` and `sign`, the magnitudes |op0| and |op1|, and the result signs.
  - Width used for magnitudes: 16 bits if `len=1`, otherwise 8 bits from `op0[7:0]`.
  - Quotient sign: sign(dividend) XOR sign(divisor).
  - Remainder sign: sign(dividend).
- Divide core: restoring division on the magnitudes, MSB first, with a 9-bit partial remainder. Iteration count is N=16 (`len=1`) or N=8 (`len=0`).
- Signed result rule: the quotient truncates toward zero, and the remainder takes the dividend's sign. The magnitude identity |dividend| = |quot|·|divisor| + |rem| holds.
- 8-bit mode result format:
  - `quot[15:8]` is zero-extended when unsigned.
  - `quot[15:8]` is sign-extended from the true quotient when signed.
- Divide by zero (`op1==0`):
  - No iteration is performed.
  - Result: `v=1`, `quot=16'hFFFF`, `rem=op0[7:0]`.
- Signed overflow: the true quotient does not fit the signed width selected by `len` (16 bits, or 8 bits for `len=0`).
  - `v=1`.
  - `quot` = the low 16 bits of the true quotient (0x8000 for -32768/-1, 0x0080 for -128/-1).
  - `rem=0`.
- Unsigned mode never overflows except on divide by zero.
- Output update: `quot`, `rem` and `v` hold their previous values until the DONE load. All three update on the same edge as the `busy` fall.
- Reset during RUN aborts the division. All outputs return to their reset values.

## Timing
- Edge 0 is the edge that accepts `start`. `busy` is high from edge 0 onward.
- Normal division: `busy` stays high for exactly N `cen` cycles and falls on the Nth enabled edge after edge 0. Results are valid on that same edge.
- Divide by zero: `busy` stays high for exactly one `cen` cycle.
- Cycles with `cen=0` freeze every register. Latency counts only enabled cycles.
- Back-to-back requests: `start` on the `cen` cycle in which `busy` is low (including the cycle right after the fall) is accepted. Zero bubble is required beyond that.
- `busy` is a pure register output, with no combinational path from `start`.

## Structure
- Iteration counts (16/8) and the state encoding are local parameters of the module.
- Nothing is added to the shared `jtkcpu.inc` include.
- No sub-module is needed. Magnitude extraction and negation are local functions.
- Target size is 150–250 lines.

## Test plan
- Unsigned 16/8: `op0=0x1234`, `op1=0x10`, `len=1`, `sign=0` -> `quot=0x0123`, `rem=0x04`, `v=0`, `busy` high for 16 `cen` cycles.
- Signed 16/8: `op0=0xFF9C` (-100), `op1=0x07`, `sign=1` -> `quot=0xFFF2` (-14), `rem=0xFE` (-2), `v=0`.
- Unsigned 8/8: `op0=0x55C8`, `op1=0x0F`, `len=0` -> `quot=0x000D`, `rem=0x05`, `busy` high for 8 `cen` cycles.
- Divide by zero: `op0=0x00AB`, `op1=0x00` -> `v=1`, `quot=0xFFFF`, `rem=0xAB`, `busy` high for 1 `cen` cycle.
- Signed overflow: `op0=0x8000`, `op1=0xFF`, `sign=1`, `len=1` -> `v=1`, `quot=0x8000`, `rem=0x00`.
- Control corner cases, each a separate run:
  - `cen` toggling 1-in-3 during a division -> the first test's result arrives after 16 enabled cycles.
  - `start` pulsed mid-RUN -> ignored; the original result is unchanged.
  - `rst` asserted mid-RUN -> all outputs 0. A fresh `start` afterwards completes correctly.
